// File: rtl/imm_encoder_pkg.sv
// Shared definitions for the ARM data-processing immediate encoder.
// Holds the word/field widths, the largest rotation index and the
// search FSM state encoding used by imm_encoder.
package imm_encoder_pkg;

    localparam int WIDTH    = 32;
    localparam int ROT_BITS = 4;
    localparam int IMM_BITS = 8;
    localparam int ROT_MAX  = (2 ** ROT_BITS) - 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_e;

endpackage

// File: rtl/imm_encoder_rotl_even.sv
// Combinational even rotate-left: dout = din ROL (2*rot), amount taken
// modulo WIDTH. This undoes the extender's Imm8 ROR (2*Rot), so a
// candidate rotation is valid when the rotated word fits in the low byte.
// Ports:
//   din  - word to rotate
//   rot  - rotation index; the shift is twice this value
//   dout - rotated word
module rotl_even #(
    parameter int WIDTH    = 32,
    parameter int ROT_BITS = 4
) (
    input  logic [WIDTH-1:0]    din,
    input  logic [ROT_BITS-1:0] rot,
    output logic [WIDTH-1:0]    dout
);

    logic [31:0] shamt;

    always_comb begin
        shamt = (32'(rot) << 1) % 32'(WIDTH);
        // Shifting the doubled word left and keeping the upper half
        // wraps the bits that fall off the top back into the bottom.
        dout  = WIDTH'(({din, din} << shamt) >> WIDTH);
    end

endmodule

// File: rtl/imm_encoder.sv
// Multi-cycle encoder for ARM data-processing immediates. A request
// latches a 32-bit constant, then one rotation per cycle is tried in
// ascending order; the first rotation that brings the constant into the
// low byte gives the canonical Imm12 = {Rot, Imm8}.
// Ports:
//   CLK       - rising-edge clock
//   RESET     - synchronous reset, active-high
//   Start     - request, accepted in IDLE or DONE only
//   Value     - constant to encode, sampled on the accepting edge
//   Busy      - high while searching
//   Done      - one-cycle pulse when Encodable/Imm12 carry a new result
//   Encodable - 1 when Value can be expressed as an immediate
//   Imm12     - {Rot, Imm8}, zero when not encodable; holds until next result
module imm_encoder
    import imm_encoder_pkg::*;
(
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         Start,
    input  logic [WIDTH-1:0]             Value,
    output logic                         Busy,
    output logic                         Done,
    output logic                         Encodable,
    output logic [ROT_BITS+IMM_BITS-1:0] Imm12
);

    localparam logic [ROT_BITS-1:0] ROT_LAST = ROT_BITS'(ROT_MAX);

    state_e                        state_q, state_d;
    logic [WIDTH-1:0]              value_q, value_d;
    logic [ROT_BITS-1:0]           rot_q, rot_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;
    logic                          enc_q, enc_d;
    logic [ROT_BITS+IMM_BITS-1:0]  imm_q, imm_d;

    logic [WIDTH-1:0]              cand;
    logic                          match;

    rotl_even #(
        .WIDTH    (WIDTH),
        .ROT_BITS (ROT_BITS)
    ) u_rotl (
        .din  (value_q),
        .rot  (rot_q),
        .dout (cand)
    );

    assign match = (cand[WIDTH-1:IMM_BITS] == '0);

    always_comb begin
        state_d = state_q;
        value_d = value_q;
        rot_d   = rot_q;
        done_d  = 1'b0;
        enc_d   = enc_q;
        imm_d   = imm_q;

        case (state_q)
            IDLE, DONE: begin
                if (Start) begin
                    value_d = Value;
                    rot_d   = '0;
                    state_d = SEARCH;
                end else begin
                    state_d = IDLE;
                end
            end
            SEARCH: begin
                if (match) begin
                    imm_d   = {rot_q, cand[IMM_BITS-1:0]};
                    enc_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else if (rot_q == ROT_LAST) begin
                    imm_d   = '0;
                    enc_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    rot_d   = rot_q + ROT_BITS'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered, so they are derived from the next state.
        busy_d = (state_d == SEARCH);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            value_q <= '0;
            rot_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            enc_q   <= 1'b0;
            imm_q   <= '0;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            rot_q   <= rot_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            enc_q   <= enc_d;
            imm_q   <= imm_d;
        end
    end

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Encodable = enc_q;
    assign Imm12     = imm_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder and its rotl_even helper.
module tb_imm_encoder;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        Start;
    logic [31:0] Value;
    logic        Busy;
    logic        Done;
    logic        Encodable;
    logic [11:0] Imm12;

    logic [31:0] r_din;
    logic [3:0]  r_rot;
    logic [31:0] r_dout;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    imm_encoder dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .Start     (Start),
        .Value     (Value),
        .Busy      (Busy),
        .Done      (Done),
        .Encodable (Encodable),
        .Imm12     (Imm12)
    );

    rotl_even #(.WIDTH(32), .ROT_BITS(4)) u_rot (
        .din  (r_din),
        .rot  (r_rot),
        .dout (r_dout)
    );

    // Reference extender: Imm8 ROR (2*Rot).
    function automatic logic [31:0] extend(input logic [11:0] imm);
        logic [31:0] x;
        int          s;
        x = {24'h0, imm[7:0]};
        s = 2 * int'(imm[11:8]);
        if (s == 0) return x;
        return (x >> s) | (x << (32 - s));
    endfunction

    // Counts edges after the accepting edge until Done is seen.
    task automatic wait_done(output int n, output bit timed_out);
        n = 0;
        do begin
            @(posedge CLK); #1;
            n++;
        end while (!Done && n < 40);
        timed_out = !Done;
    endtask

    task automatic test_reset();
        RESET = 1'b1; Start = 1'b0; Value = '0;
        repeat (2) @(posedge CLK);
        #1;
        tests++; if (Busy !== 1'b0)      begin fails++; $display("FAIL reset_busy got %b want 0", Busy); end
        tests++; if (Done !== 1'b0)      begin fails++; $display("FAIL reset_done got %b want 0", Done); end
        tests++; if (Encodable !== 1'b0) begin fails++; $display("FAIL reset_enc got %b want 0", Encodable); end
        tests++; if (Imm12 !== 12'h000)  begin fails++; $display("FAIL reset_imm got %h want 000", Imm12); end
        RESET = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic test_vectors();
        logic [31:0] v   [6];
        int          lat [6];
        logic        enc [6];
        logic [11:0] imm [6];
        int          n;
        bit          to;
        v[0] = 32'h0000_00FF; lat[0] = 2;  enc[0] = 1'b1; imm[0] = 12'h0FF;
        v[1] = 32'hF000_000F; lat[1] = 4;  enc[1] = 1'b1; imm[1] = 12'h2FF;
        v[2] = 32'hFF00_0000; lat[2] = 6;  enc[2] = 1'b1; imm[2] = 12'h4FF;
        v[3] = 32'h0000_03FC; lat[3] = 17; enc[3] = 1'b1; imm[3] = 12'hFFF;
        v[4] = 32'h0000_0101; lat[4] = 17; enc[4] = 1'b0; imm[4] = 12'h000;
        v[5] = 32'h0000_0000; lat[5] = 2;  enc[5] = 1'b1; imm[5] = 12'h000;
        for (int i = 0; i < 6; i++) begin
            Start = 1'b1; Value = v[i];
            @(posedge CLK); #1;
            Start = 1'b0; Value = 32'hDEAD_BEEF;
            tests++; if (Busy !== 1'b1) begin fails++; $display("FAIL vec%0d_busy_start got %b want 1", i, Busy); end
            wait_done(n, to);
            tests++;
            if (to) begin
                fails++; $display("FAIL vec%0d_timeout no Done within 40 cycles", i);
            end else begin
                if (n + 1 != lat[i]) begin fails++; $display("FAIL vec%0d_latency got %0d want %0d", i, n + 1, lat[i]); end
                tests++; if (Encodable !== enc[i]) begin fails++; $display("FAIL vec%0d_enc got %b want %b", i, Encodable, enc[i]); end
                tests++; if (Imm12 !== imm[i])     begin fails++; $display("FAIL vec%0d_imm got %h want %h", i, Imm12, imm[i]); end
                tests++; if (Busy !== 1'b0)        begin fails++; $display("FAIL vec%0d_busy_done got %b want 0", i, Busy); end
                if (enc[i]) begin
                    tests++;
                    if (extend(Imm12) !== v[i]) begin fails++; $display("FAIL vec%0d_extend got %h want %h", i, extend(Imm12), v[i]); end
                end
                @(posedge CLK); #1;
                tests++; if (Done !== 1'b0) begin fails++; $display("FAIL vec%0d_done_pulse got %b want 0", i, Done); end
            end
        end
    endtask

    // Start stays high through the search while Value keeps changing;
    // returns with Done visible and Start still high.
    task automatic test_start_held();
        int n;
        Start = 1'b1; Value = 32'hFF00_0000;
        @(posedge CLK); #1;
        n = 0;
        do begin
            Value = 32'h0000_0101 << n;
            @(posedge CLK); #1;
            n++;
        end while (!Done && n < 40);
        tests++;
        if (!Done) begin
            fails++; $display("FAIL held_timeout no Done within 40 cycles");
        end else begin
            if (n + 1 != 6) begin fails++; $display("FAIL held_latency got %0d want 6", n + 1); end
            tests++; if (Imm12 !== 12'h4FF)   begin fails++; $display("FAIL held_imm got %h want 4FF", Imm12); end
            tests++; if (Encodable !== 1'b1)  begin fails++; $display("FAIL held_enc got %b want 1", Encodable); end
        end
    endtask

    // Start is still high in the DONE cycle: the next search starts at once.
    task automatic test_back_to_back();
        int n;
        bit to;
        Value = 32'h0000_00FF;
        @(posedge CLK); #1;
        Start = 1'b0;
        tests++; if (Busy !== 1'b1) begin fails++; $display("FAIL b2b_busy got %b want 1", Busy); end
        tests++; if (Done !== 1'b0) begin fails++; $display("FAIL b2b_done got %b want 0", Done); end
        tests++; if (Imm12 !== 12'h4FF) begin fails++; $display("FAIL b2b_hold_imm got %h want 4FF", Imm12); end
        wait_done(n, to);
        tests++;
        if (to) begin
            fails++; $display("FAIL b2b_timeout no Done within 40 cycles");
        end else begin
            if (n + 1 != 2) begin fails++; $display("FAIL b2b_latency got %0d want 2", n + 1); end
            tests++; if (Imm12 !== 12'h0FF) begin fails++; $display("FAIL b2b_imm got %h want 0FF", Imm12); end
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_reset_abort();
        int n;
        bit to;
        Start = 1'b1; Value = 32'h0000_03FC;
        @(posedge CLK); #1;
        Start = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b1;
        @(posedge CLK); #1;
        tests++; if (Busy !== 1'b0)      begin fails++; $display("FAIL abort_busy got %b want 0", Busy); end
        tests++; if (Done !== 1'b0)      begin fails++; $display("FAIL abort_done got %b want 0", Done); end
        tests++; if (Encodable !== 1'b0) begin fails++; $display("FAIL abort_enc got %b want 0", Encodable); end
        tests++; if (Imm12 !== 12'h000)  begin fails++; $display("FAIL abort_imm got %h want 000", Imm12); end
        RESET = 1'b0;
        repeat (20) begin
            @(posedge CLK); #1;
            tests++; if (Done !== 1'b0 || Busy !== 1'b0) begin fails++; $display("FAIL abort_idle done=%b busy=%b want 0/0", Done, Busy); end
        end
        Start = 1'b1; Value = 32'hF000_000F;
        @(posedge CLK); #1;
        Start = 1'b0;
        wait_done(n, to);
        tests++;
        if (to) begin
            fails++; $display("FAIL abort_restart_timeout no Done within 40 cycles");
        end else begin
            if (n + 1 != 4) begin fails++; $display("FAIL abort_restart_latency got %0d want 4", n + 1); end
            tests++; if (Imm12 !== 12'h2FF) begin fails++; $display("FAIL abort_restart_imm got %h want 2FF", Imm12); end
        end
    endtask

    task automatic test_rotl();
        logic [31:0] din [4];
        logic [3:0]  rot [4];
        logic [31:0] exp [4];
        logic [11:0] imm;
        din[0] = 32'h0000_03FC; rot[0] = 4'd15; exp[0] = 32'h0000_00FF;
        din[1] = 32'hF000_000F; rot[1] = 4'd2;  exp[1] = 32'h0000_00FF;
        din[2] = 32'h1234_5678; rot[2] = 4'd0;  exp[2] = 32'h1234_5678;
        din[3] = 32'h8000_0001; rot[3] = 4'd1;  exp[3] = 32'h0000_0006;
        for (int i = 0; i < 4; i++) begin
            r_din = din[i]; r_rot = rot[i];
            #1;
            tests++; if (r_dout !== exp[i]) begin fails++; $display("FAIL rotl%0d got %h want %h", i, r_dout, exp[i]); end
        end
        for (int r = 0; r < 16; r++) begin
            imm   = {4'(r), 8'hA5};
            r_din = extend(imm); r_rot = 4'(r);
            #1;
            tests++; if (r_dout !== 32'h0000_00A5) begin fails++; $display("FAIL rotl_inv_rot%0d got %h want 000000a5", r, r_dout); end
        end
    endtask

    initial begin
        r_din = '0; r_rot = '0;
        test_reset();
        test_vectors();
        test_start_held();
        test_back_to_back();
        test_reset_abort();
        test_rotl();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Multi-cycle encoder for ARM data-processing immediates, the inverse of the existing immediate extender.
- The extender computes ExtImm = Imm8 ROR (2*Rot) from Imm12 = {Rot[3:0], Imm8[7:0]}.
- This block takes a 32-bit constant, searches the 16 rotations one per cycle, and returns an encodable flag plus the canonical Imm12 (the smallest Rot that works).
- It sits beside the assembler/immediate-load path in the Core and feeds Imm12 back into the existing datapath.

Parameters:
- WIDTH, 32, data word width
- ROT_BITS, 4, width of the rotate field; 2**ROT_BITS candidate rotations
- IMM_BITS, 8, width of the unrotated immediate field

Ports:
- CLK  in  1  rising-edge clock
- RESET  in  1  synchronous reset, active-high
- Start  in  1  request; accepted only in IDLE or DONE
- Value  in  WIDTH  constant to encode; sampled on the accepted Start edge
- Busy  out  1  high while in SEARCH
- Done  out  1  one-cycle pulse when a result is valid
- Encodable  out  1  1 = Value is representable
- Imm12  out  ROT_BITS+IMM_BITS  {Rot, Imm8}; 0 when not encodable

Behaviour:
- One clock, CLK. RESET is synchronous and active-high.
- Reset:
  - State = IDLE.
  - Busy = 0, Done = 0, Encodable = 0, Imm12 = 0.
  - Internal ValueReg = 0, RotCnt = 0.
- States are IDLE, SEARCH and DONE.
- IDLE:
  - On Start=1, latch ValueReg <= Value, set RotCnt <= 0, go to SEARCH.
  - Busy = 1 from the next cycle.
- SEARCH, each cycle:
  - Cand = ValueReg ROL (2*RotCnt), computed mod WIDTH.
  - Match when Cand[WIDTH-1:IMM_BITS] == 0.
  - On Match: Imm12 <= {RotCnt, Cand[7:0]}, Encodable <= 1, go to DONE.
  - No Match and RotCnt == 15: Imm12 <= 0, Encodable <= 0, go to DONE.
  - Otherwise RotCnt <= RotCnt + 1.
  - RotCnt is compared at 15 before increment and never wraps.
- DONE:
  - Done = 1 for exactly this one cycle; Busy = 0.
  - Next state is IDLE, unless Start=1, which is accepted as in IDLE (back-to-back requests).
- Latency: if Start is accepted at edge T and the first match is at rotation k, Done is high in the cycle after edge T+k+1.
  - Best case 2 cycles (k=0).
  - Worst case 17 cycles (k=15 or not encodable).
- Canonical result: ascending search, so the smallest Rot always wins (e.g. Value=0 gives Imm12=0x000).
- Encodable and Imm12 hold their last result until the next DONE; they are not cleared on Start.
- Start while Busy is ignored. Value changes after acceptance are ignored.
- RESET during SEARCH or DONE aborts immediately to the reset values above, with no Done pulse.
- Invariant for verification: whenever Done=1 and Encodable=1, Extend(Imm12) == the accepted Value.

Decomposition:
- Shared package (imm_pkg):
  - State encoding IDLE=2'd0, SEARCH=2'd1, DONE=2'd2.
  - Constants WIDTH, ROT_BITS, IMM_BITS.
  - ROT_MAX = 2**ROT_BITS-1.
- One natural sub-module, rotl_even: combinational Cand = In ROL (2*Rot), parameterised on WIDTH/ROT_BITS.
  - Kept separate so the bench can check it against the extender's ROR.

Test Plan:
- Value=0x000000FF, Start at T -> Done at T+2, Encodable=1, Imm12=0x0FF.
- Value=0xF000000F -> Done at T+4, Encodable=1, Imm12=0x2FF; Extend(0x2FF)==0xF000000F.
- Value=0xFF000000 -> Imm12=0x4FF, Done at T+6. Value=0x000003FC (needs Rot=15) -> Imm12=0xFFF, Done at T+17.
- Value=0x00000101 -> Done at T+17, Encodable=0, Imm12=0x000.
- Start held high through SEARCH with Value changing -> result matches only the first sampled Value. Start in the DONE cycle -> second search begins with no idle gap.
- RESET asserted at T+3 during a 0x000003FC search -> next cycle all outputs 0, state IDLE, no Done. A fresh Start afterwards completes normally.
